// File: rtl/count_check_if.sv
// ============================================================================
// Module      : count_check_if
// Description : Stream, control and status bundle for the count_check monitor.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface count_check_if #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
);
    logic             en;
    logic [WIDTH-1:0] count_in;
    logic             clr_err;
    logic             locked;
    logic             err_pulse;
    logic             err_sticky;
    logic [ERR_W-1:0] err_cnt;
    logic             wrap_pulse;
    logic [7:0]       wrap_cnt;

    modport master (
        output en, count_in, clr_err,
        input  locked, err_pulse, err_sticky, err_cnt, wrap_pulse, wrap_cnt
    );

    modport slave (
        input  en, count_in, clr_err,
        output locked, err_pulse, err_sticky, err_cnt, wrap_pulse, wrap_cnt
    );
endinterface

`default_nettype wire

// File: rtl/count_check.sv
// ============================================================================
// Module      : count_check
// Description : Locks to an incrementing count stream; flags/counts errors and wraps.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module count_check #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  wire logic    clk,
    input  wire logic    rst,
    count_check_if.slave bus
);
    localparam int               c_RUN_W    = 5;
    localparam [c_RUN_W-1:0]     c_LOCK_RUN = c_RUN_W'(LOCK_CNT);
    localparam [ERR_W-1:0]       c_ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_SYNC   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_exp;
    logic [c_RUN_W-1:0] r_run;
    logic               r_locked;
    logic               r_err_pulse;
    logic               r_err_sticky;
    logic [ERR_W-1:0]   r_err_cnt;
    logic               r_wrap_pulse;
    logic [7:0]         r_wrap_cnt;

    logic               w_match;
    logic               w_zero;
    logic [WIDTH-1:0]   w_next;

    assign w_match = (bus.count_in == r_exp);
    assign w_zero  = (bus.count_in == '0);
    assign w_next  = bus.count_in + WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_HUNT;
            r_exp        <= '0;
            r_run        <= '0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
            r_wrap_pulse <= 1'b0;
            r_wrap_cnt   <= '0;
        end else begin
            r_err_pulse  <= 1'b0;
            r_wrap_pulse <= 1'b0;

            if (bus.clr_err) begin
                r_err_cnt    <= '0;
                r_err_sticky <= 1'b0;
            end

            if (bus.en) begin
                // Every sample becomes the reference for the next one.
                r_exp <= w_next;
                case (r_state)
                    S_HUNT: begin
                        r_run   <= c_RUN_W'(1);
                        r_state <= S_SYNC;
                    end
                    S_SYNC: begin
                        if (w_match) begin
                            r_run <= r_run + c_RUN_W'(1);
                            if (r_run == c_LOCK_RUN) begin
                                r_state  <= S_LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_run <= c_RUN_W'(1);
                        end
                    end
                    S_LOCKED: begin
                        if (w_match) begin
                            if (w_zero) begin
                                r_wrap_pulse <= 1'b1;
                                r_wrap_cnt   <= r_wrap_cnt + 8'd1;
                            end
                        end else begin
                            r_err_pulse  <= 1'b1;
                            r_err_sticky <= 1'b1;
                            // A simultaneous clear is applied first, then this error counts.
                            if (bus.clr_err)
                                r_err_cnt <= ERR_W'(1);
                            else if (r_err_cnt != c_ERR_MAX)
                                r_err_cnt <= r_err_cnt + ERR_W'(1);
                            r_run    <= c_RUN_W'(1);
                            r_state  <= S_SYNC;
                            r_locked <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= S_HUNT;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.locked     = r_locked;
    assign bus.err_pulse  = r_err_pulse;
    assign bus.err_sticky = r_err_sticky;
    assign bus.err_cnt    = r_err_cnt;
    assign bus.wrap_pulse = r_wrap_pulse;
    assign bus.wrap_cnt   = r_wrap_cnt;
endmodule

`default_nettype wire

// File: doc/count_check.md
Name: count_check

Overview:
- Receive-side checker for the 8-bit free-running counter stream (`count_out`) that the counter block produces.
- Samples the stream each qualified clock, locks to the incrementing sequence, then flags and counts sequence errors and wrap-arounds.
- Sits beside the counter in the datapath and in its bench, giving self-checking status without waveform inspection.

Parameters:
- WIDTH, 8, width of monitored count value.
- LOCK_CNT, 4, consecutive correct increments required to declare lock (range 1..15).
- ERR_W, 8, width of saturating error counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample qualifier; count_in is evaluated only when en=1.
- count_in  input  WIDTH  monitored count value (from counter count_out).
- clr_err  input  1  synchronous clear of err_cnt and sticky error flag.
- locked  output  1  high while in LOCKED state.
- err_pulse  output  1  one-cycle pulse on sequence error while locked.
- err_sticky  output  1  set on any err_pulse; cleared by clr_err or rst.
- err_cnt  output  ERR_W  saturating count of err_pulse events.
- wrap_pulse  output  1  one-cycle pulse when a locked stream wraps from all-ones to 0.
- wrap_cnt  output  8  count of wrap_pulse events, modulo 256.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. Reset asserted at any time forces every output to 0 immediately and the FSM to HUNT.
- Reset values:
  - locked=0, err_pulse=0, err_sticky=0, err_cnt=0, wrap_pulse=0, wrap_cnt=0.
  - Internal expected value = 0, run counter = 0.
- All outputs are registered. Response appears the cycle after the en=1 sample that causes it (latency 1).
- en=0: FSM, expected value and counters hold; err_pulse and wrap_pulse are 0.
- Expected-value arithmetic: exp = sample + 1 modulo 2^WIDTH, so all-ones+1 = 0 is a correct increment.
- FSM on each en=1 sample:
  - HUNT: load exp = count_in+1, run=1, go to SYNC.
  - SYNC, count_in==exp: run++, exp++. If run+1 == LOCK_CNT+1 (i.e. LOCK_CNT correct increments seen), go to LOCKED and set locked=1.
  - SYNC, mismatch: exp = count_in+1, run=1, stay in SYNC. No error is reported.
  - LOCKED, count_in==exp: exp++, stay.
  - LOCKED, mismatch: err_pulse=1, err_sticky=1, err_cnt++ (saturating at all-ones), exp = count_in+1, run=1, go to SYNC, locked=0.
- Wrap: in LOCKED with a matching sample where count_in==0, wrap_pulse=1 and wrap_cnt++ (natural wrap 255→0). Wraps seen in SYNC are not counted.
- clr_err:
  - Clears err_cnt and err_sticky on the next edge, independent of en.
  - If clr_err and an error occur in the same cycle, the result is err_cnt=1 and err_sticky=1 (the error is counted after the clear).
  - clr_err does not affect the FSM or wrap_cnt.
- err_pulse and wrap_pulse are never both 1: a mismatch cannot be a wrap.
- Stalled stream (count_in constant with en=1) is a mismatch each sample while locked. Only the first one pulses err, because the FSM then drops to SYNC.

Test Plan:
- rst=1 for 20 ns, then counter runs from 0 with en=1 each cycle → locked=1 on the cycle after the sample value 4 (LOCK_CNT=4); err_cnt=0.
- Locked stream runs 0..255..0 → exactly one wrap_pulse, the cycle after the sample 0 following 255; wrap_cnt=1; locked stays 1.
- Locked at value 0x20, force count_in=0x55 for one sample → err_pulse for one cycle, err_cnt=1, err_sticky=1, locked=0. After 0x56..0x59 (4 correct increments), locked=1 again.
- Inject 300 single-sample glitches, each followed by relock → err_cnt saturates at 255 and err_sticky=1. Then clr_err for one cycle → err_cnt=0, err_sticky=0.
- en toggles 1/0 with the counter advancing only on en=1 cycles → lock is reached and no errors occur; both pulses are 0 on every en=0 cycle.
- Assert rst mid-stream while locked with err_cnt=3 → all outputs 0 asynchronously, before the next clk edge. After release, relock takes LOCK_CNT increments again.
